// File: rtl/div_result_display_pkg.sv
// Shared types and seven-segment encodings for the divider result display.
// Codes are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pin register.
package div_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int unsigned DABBLE_ITERS = 4;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/div_result_display_if.sv
// Result handshake from the divider into the display stage.
interface div_result_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (output in_valid, quotient, remainder, div_by_zero, input in_ready);
  modport slave  (input in_valid, quotient, remainder, div_by_zero, output in_ready);
endinterface

// File: rtl/div_result_display_bcd_dabble4.sv
// One double-dabble step on {tens, units, bin}: add-3 correction on units, then shift left.
// Tens is never corrected because a 4-bit input cannot push it past 1.
module bcd_dabble4 (
  input  logic [11:0] dd_in,
  output logic [11:0] dd_out
);

  logic [3:0] units_adj;

  always_comb begin
    units_adj = (dd_in[7:4] >= 4'd5) ? (dd_in[7:4] + 4'd3) : dd_in[7:4];
    dd_out    = {dd_in[10:8], units_adj, dd_in[3:0], 1'b0};
  end

endmodule

// File: rtl/div_result_display.sv
// Captures a quotient/remainder pair, converts both to BCD, and scans them onto a
// four-digit multiplexed seven-segment display (quotient left, remainder right).
module div_result_display
  import div_display_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  div_result_display_if.slave  in_if,
  output logic                 busy,
  output logic [6:0]           seg,
  output logic [3:0]           an
);

  localparam int unsigned   CW        = ($clog2(SCAN_CYCLES) > 10) ? $clog2(SCAN_CYCLES) : 10;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  // XOR mask that turns an active-high code into the pin polarity.
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t          state_q, state_d;
  logic [1:0]      iter_q, iter_d;
  logic [11:0]     q_dd_q, q_dd_d, q_step;
  logic [11:0]     r_dd_q, r_dd_d, r_step;
  logic            dbz_q, dbz_d;
  logic [3:0][6:0] code_q, code_d, code_new;
  logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  bcd_dabble4 u_dabble_q (.dd_in(q_dd_q), .dd_out(q_step));
  bcd_dabble4 u_dabble_r (.dd_in(r_dd_q), .dd_out(r_step));

  always_comb begin : digit_map
    code_new[3] = (q_dd_q[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(q_dd_q[11:8]);
    code_new[2] = bcd_to_seg(q_dd_q[7:4]);
    code_new[1] = (r_dd_q[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(r_dd_q[11:8]);
    code_new[0] = bcd_to_seg(r_dd_q[7:4]);
    if (dbz_q) begin
      code_new = {4{SEG_DASH}};
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    iter_d  = iter_q;
    q_dd_d  = q_dd_q;
    r_dd_d  = r_dd_q;
    dbz_d   = dbz_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (in_if.in_valid && in_ready_q) begin
          q_dd_d  = {8'd0, in_if.quotient};
          r_dd_d  = {8'd0, in_if.remainder};
          dbz_d   = in_if.div_by_zero;
          iter_d  = 2'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        q_dd_d = q_step;
        r_dd_d = r_step;
        iter_d = iter_q + 2'd1;
        if (iter_q == 2'(DABBLE_ITERS - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        code_d  = code_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_comb begin : scan_next
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    idx_d      = (scan_cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    // Using next-state code and index lets a LOAD and a scan advance land on the same edge.
    an_d       = ~(4'b0001 << idx_d);
    seg_d      = code_d[idx_d] ^ SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iter_q     <= 2'd0;
      q_dd_q     <= '0;
      r_dd_q     <= '0;
      dbz_q      <= 1'b0;
      code_q     <= {4{SEG_BLANK}};
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= 4'b1110;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      q_dd_q     <= q_dd_d;
      r_dd_q     <= r_dd_d;
      dbz_q      <= dbz_d;
      code_q     <= code_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign seg            = seg_q;
  assign an             = an_q;

endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: directed and random results checked every cycle
// against an arithmetic model of the display contents, scan position and handshake.
module tb_div_result_display;

  localparam int unsigned SCAN = 4;
  localparam bit          SAL  = 1'b1;
  localparam logic [6:0]  DIGIT_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0]  DASH  = 7'h40;
  localparam logic [6:0]  BLANK = 7'h00;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  div_result_display_if bus ();

  div_result_display #(.SCAN_CYCLES(SCAN), .SEG_ACTIVE_LOW(SAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (bus),
    .busy  (busy),
    .seg   (seg),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the display should show, derived from decimal arithmetic.
  int              m_cyc;
  int              m_left;
  int              m_acc;
  logic [3:0][6:0] m_codes;
  logic [3:0][6:0] m_pend;

  function automatic logic [3:0][6:0] codes_of(input int q, input int r, input bit z);
    logic [3:0][6:0] c;
    if (z) begin
      c = {DASH, DASH, DASH, DASH};
    end else begin
      c[3] = (q / 10 == 0) ? BLANK : DIGIT_SEG[q / 10];
      c[2] = DIGIT_SEG[q % 10];
      c[1] = (r / 10 == 0) ? BLANK : DIGIT_SEG[r / 10];
      c[0] = DIGIT_SEG[r % 10];
    end
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   <= 0;
      m_left  <= 0;
      m_codes <= {BLANK, BLANK, BLANK, BLANK};
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_codes <= m_pend;
      end else if (bus.in_valid) begin
        m_pend <= codes_of(int'(bus.quotient), int'(bus.remainder), bus.div_by_zero);
        m_left <= 5;
        m_acc  <= m_acc + 1;
      end
    end
  end

  task automatic check_now(input string tag);
    int         idx;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    idx     = (m_cyc / SCAN) % 4;
    exp_an  = 4'b1111;
    exp_an[idx] = 1'b0;
    exp_seg = SAL ? ~m_codes[idx] : m_codes[idx];
    n_tests++;
    assert (bus.in_ready === (m_left == 0)) else begin
      n_fail++;
      $error("FAIL %s in_ready: got %b want %b", tag, bus.in_ready, (m_left == 0));
    end
    n_tests++;
    assert (busy === (m_left != 0)) else begin
      n_fail++;
      $error("FAIL %s busy: got %b want %b", tag, busy, (m_left != 0));
    end
    n_tests++;
    assert (an === exp_an) else begin
      n_fail++;
      $error("FAIL %s an: got %b want %b", tag, an, exp_an);
    end
    n_tests++;
    assert (seg === exp_seg) else begin
      n_fail++;
      $error("FAIL %s seg: got %h want %h (digit %0d)", tag, seg, exp_seg, idx);
    end
  endtask

  task automatic tick(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now(tag);
    end
  endtask

  task automatic wait_accept(input string tag);
    int start;
    int k;
    start = m_acc;
    k = 0;
    while (m_acc == start && k < 20) begin
      tick(tag, 1);
      k++;
    end
    n_tests++;
    assert (m_acc != start) else begin
      n_fail++;
      $error("FAIL %s accept: got timeout want handshake", tag);
    end
  endtask

  task automatic send(input string tag, input int q, input int r, input bit z);
    bus.quotient    = 4'(q);
    bus.remainder   = 4'(r);
    bus.div_by_zero = z;
    bus.in_valid    = 1'b1;
    wait_accept(tag);
    bus.in_valid    = 1'b0;
    bus.quotient    = 4'($urandom_range(0, 15));
    bus.remainder   = 4'($urandom_range(0, 15));
    $display("[TB] %s q=%0d r=%0d dbz=%0d", tag, q, r, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_acc           = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.quotient    = 4'd0;
    bus.remainder   = 4'd0;
    bus.div_by_zero = 1'b0;
    tick("reset", 3);
    rst_n = 1'b1;
    tick("scan_blank", 20);

    send("q6_r0", 6, 0, 1'b0);
    tick("q6_r0", 22);

    send("q15_r3", 15, 3, 1'b0);
    tick("q15_r3", 22);

    send("dbz", 9, 4, 1'b1);
    tick("dbz", 22);

    // Held valid with new data during conversion: second result taken only from IDLE.
    bus.quotient = 4'd12; bus.remainder = 4'd7; bus.div_by_zero = 1'b0;
    bus.in_valid = 1'b1;
    wait_accept("hold_a");
    $display("[TB] hold_a q=12 r=7 dbz=0");
    bus.quotient = 4'd8; bus.remainder = 4'd11;
    wait_accept("hold_b");
    bus.in_valid = 1'b0;
    $display("[TB] hold_b q=8 r=11 dbz=0");
    tick("hold_b", 22);

    // Asynchronous reset in the middle of a conversion.
    send("rst_mid", 13, 10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("rst_async");
    $display("[TB] rst_mid reset asserted during CONV");
    @(negedge clk);
    check_now("rst_hold");
    rst_n = 1'b1;
    tick("rst_after", 24);

    for (int t = 0; t < 12; t++) begin
      send("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0));
      tick("rand", int'($urandom_range(6, 20)));
    end
    tick("tail", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_result_display.md
# div_result_display

Downstream display stage for the 4-bit divider. Accepts one quotient/remainder pair per valid/ready handshake and converts each value to two BCD digits with a sequential double-dabble. It then drives a four-digit time-multiplexed seven-segment display, showing quotient on the left pair and remainder on the right pair. A divide-by-zero flag replaces the result with dashes.

## Interface
- SCAN_CYCLES, 1024, clock cycles each digit stays enabled before the scan advances (≥2)
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode), 0 = active-high
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  quotient/remainder/div_by_zero valid
- in_ready  output  1  block can accept a result
- quotient  input  4  divider quotient, unsigned
- remainder  input  4  divider remainder, unsigned
- div_by_zero  input  1  divisor was zero; result invalid
- busy  output  1  conversion in progress (CONV or LOAD)
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an  output  4  digit enables, active-low one-hot; an[3] = leftmost

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture quotient, remainder and div_by_zero, clear the shift count, go to CONV.
  - CONV: 4 iterations, one per cycle, on both values in parallel.
  - LOAD: 1 cycle. Copy the digit codes into the display registers, then go to IDLE.
- in_ready=1 only in IDLE. busy=1 in CONV and LOAD.
- Double-dabble per value: 12-bit register {tens[3:0], units[3:0], bin[3:0]}. Each iteration: if units≥5 then units+=3, then shift the whole register left by 1. Tens never reaches 5 for inputs ≤15.
- Digit code mapping:
  - an[3] = quotient tens, an[2] = quotient units, an[1] = remainder tens, an[0] = remainder units.
  - A tens digit equal to 0 shows BLANK; units always show.
  - div_by_zero captured as 1: all four codes = DASH; quotient and remainder are ignored.
- Scanner runs continuously, independent of the FSM.
  - 10-bit-min counter counts 0..SCAN_CYCLES-1. At terminal count it wraps to 0 and the 2-bit digit index increments mod 4 (3→0).
  - an = ~(1<<index).
  - seg = code[index], inverted if SEG_ACTIVE_LOW.
- The display keeps the previous result during CONV; the new result appears atomically at LOAD.

## Timing
- Reset values:
  - FSM = IDLE, in_ready=1, busy=0.
  - Scan counter and index = 0, an=4'b1110.
  - All display codes = BLANK, so seg=7'h7F when SEG_ACTIVE_LOW=1 and 7'h00 otherwise.
- seg and an are registered and change only on the scan-advance edge or the LOAD edge.
- Latency: with the handshake at edge N, CONV runs over edges N+1..N+4, the display registers update at edge N+5, and in_ready is 1 again after edge N+5. The sustained rate is one result per 6 cycles.
- in_valid while in_ready=0 is not accepted. The producer holds the data; inputs are don't-care after capture.
- Scan advance coinciding with LOAD: the index advances and the new code is shown at the same edge.
- rst_n asserted mid-CONV/LOAD: the conversion is abandoned, the FSM returns to IDLE, and the display returns to BLANK immediately (asynchronous).
- Reset release is used synchronously: the first capture is possible at the first edge after deassertion.

## Structure
- Package div_display_pkg:
  - State enum {IDLE, CONV, LOAD}.
  - 7-bit active-high codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, DASH=40, BLANK=00.
  - Function bcd_to_seg.
- One sub-module, bcd_dabble4: a single 4-bit double-dabble iterator (add-3 plus shift, combinational). It is instantiated twice and the FSM registers its output.

## Test plan
- Reset, no input, SCAN_CYCLES=4 → an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; seg=7F throughout.
- quotient=6, remainder=0, in_valid for 1 cycle → in_ready low 5 cycles; after edge N+5 the digits are BLANK, 6(7D), BLANK, 0(3F), shown inverted on seg.
- quotient=15, remainder=3 → digits 1(06), 5(6D), BLANK, 3(4F); the previous result stays shown until edge N+5.
- div_by_zero=1, quotient=9 → all four digits DASH (seg=7'h3F inverted).
- New in_valid held during CONV with different data → ignored until IDLE, then accepted; exactly two results displayed in order.
- rst_n pulsed at CONV cycle 2 → in_ready=1, busy=0, seg blank, an=1110 immediately; no stale result appears afterward.
